vproc_mem_responder: RTL and testbench
======================================

// Module: vproc_mem_responder
// PURPOSE
// Synthesizable memory responder: the far end of the vproc_top data/instr memory port
// (mem_req/addr/we/be/wdata -> mem_rvalid/err/rdata). Single-ported word RAM with a fixed,
// configurable response latency and fully pipelined, in-order responses. Replaces the
// behavioural memory array in simulation benches and serves as on-chip scratch RAM in FPGA
// builds. Also flags end-of-program (request to address 0) and keeps request/error counters.
// PARAMETERS
// MEM_W        32      data width in bits (multiple of 8)
// MEM_SZ       262144  memory size in bytes (power of 2)
// MEM_LATENCY  1       request-to-response latency in cycles (>=1)
// ADDR_OFFSET  0       byte address mapped to RAM word 0 (subtracted before decode)
// INIT_FILE    ""      $readmemh image loaded at time 0; empty string = RAM not initialised
// PORTS
// clk_i        in   1          clock, all state on rising edge
// rst_ni       in   1          asynchronous reset, active low
// mem_req_i    in   1          request valid; accepted every cycle it is high (no grant)
// mem_addr_i   in   32         byte address
// mem_we_i     in   1          1 = write, 0 = read
// mem_be_i     in   MEM_W/8    byte enables (writes only)
// mem_wdata_i  in   MEM_W      write data
// mem_rvalid_o out  1          response valid, one cycle per accepted request
// mem_err_o    out  1          response error, qualified by mem_rvalid_o
// mem_rdata_o  out  MEM_W      read data, qualified by mem_rvalid_o
// prog_end_o   out  1          one-cycle pulse: request seen to address 32'h0
// req_cnt_o    out  32         accepted requests since reset (wraps)
// err_cnt_o    out  16         error responses since reset (saturates at 16'hFFFF)
// BEHAVIOUR
// - Reset (rst_ni low, async): rvalid pipeline cleared; mem_rvalid_o=0, mem_err_o=0,
//   mem_rdata_o=0, prog_end_o=0, req_cnt_o=0, err_cnt_o=0. RAM contents not reset.
// - Decode: rel = mem_addr_i - ADDR_OFFSET (32-bit, wrapping); err = rel[31:$clog2(MEM_SZ)]!=0;
//   idx = rel[$clog2(MEM_SZ)-1:$clog2(MEM_W/8)]; sub-word address bits ignored.
// - Accept: at rising edge with mem_req_i=1. Write with err=0 updates only bytes with
//   mem_be_i[i]=1; err=1 write leaves RAM unchanged. be=0 write is a legal no-op.
// - Read: data sampled from RAM at accept edge; sees all writes accepted on earlier edges.
// - Response: request accepted at edge k -> mem_rvalid_o high for exactly the cycle after
//   edge k+MEM_LATENCY-1 (LATENCY=1: the cycle after accept). Writes also get a response
//   (rdata=0). Err response: mem_err_o=1, mem_rdata_o=0. No response ever without request.
// - Pipeline: MEM_LATENCY-deep shift register of {valid,err,rdata}; back-to-back requests
//   every cycle yield back-to-back responses in request order; no stalls, no reordering.
// - When mem_rvalid_o=0: mem_err_o=0, mem_rdata_o holds 0.
// - prog_end_o: registered, high the cycle after any accepted request with mem_addr_i==0
//   (raw address, before offset), independent of err/we.
// - req_cnt_o +1 per accepted request (wraps 2^32-1 -> 0). err_cnt_o +1 per accepted
//   request with err=1, saturating; both update at accept edge.
// - Reset mid-operation: all in-flight responses dropped, never emitted after reset
//   release; writes accepted before reset assertion remain in RAM.
// - MEM_LATENCY=0 or non-power-of-2 MEM_SZ: elaboration error ($fatal).
// TESTING
// 1. LAT=1: write 0xDEADBEEF be=1111 @0x100, read @0x100 next cycle -> rvalid 1 cycle
//    later, rdata=0xDEADBEEF, err=0.
// 2. Byte enables: 0x11223344 @0x40, then write 0xAABBCCDD be=0101 -> read gives 0x11BB33DD.
// 3. LAT=3: reads @0x0,0x4,0x8,0xC on 4 consecutive cycles -> 4 consecutive rvalid,
//    first 3 cycles after first req, data in order; prog_end_o pulses once; req_cnt_o=4.
// 4. Out of range: read @MEM_SZ -> rvalid with err=1, rdata=0, err_cnt_o=1; write there
//    leaves RAM word 0 unchanged.
// 5. ADDR_OFFSET=0x2000: write @0x2010 then read RAM via @0x2010 -> same data;
//    access @0x1FFC -> err=1.
// 6. LAT=4: 3 reads issued, rst_ni pulsed low for 1 cycle mid-flight -> no rvalid after
//    reset, counters 0, earlier writes still readable.

Source files
------------

// File: rtl/vproc_mem_responder.sv
// Fixed-latency, fully pipelined single-port word RAM responder for the vproc memory port.
// Also raises an end-of-program pulse and keeps request and error counters.
module vproc_mem_responder #(
    parameter int unsigned MEM_W       = 32,
    parameter int unsigned MEM_SZ      = 262144,
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] ADDR_OFFSET = 32'h0000_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mem_req_i,
    input  logic [31:0]          mem_addr_i,
    input  logic                 mem_we_i,
    input  logic [MEM_W/8-1:0]   mem_be_i,
    input  logic [MEM_W-1:0]     mem_wdata_i,
    output logic                 mem_rvalid_o,
    output logic                 mem_err_o,
    output logic [MEM_W-1:0]     mem_rdata_o,
    output logic                 prog_end_o,
    output logic [31:0]          req_cnt_o,
    output logic [15:0]          err_cnt_o
);

    localparam int unsigned NB    = MEM_W / 8;
    localparam int unsigned AW    = $clog2(MEM_SZ);
    localparam int unsigned BW    = $clog2(NB);
    localparam int unsigned DEPTH = MEM_SZ / NB;

    if (MEM_LATENCY < 1) begin : g_bad_latency
        $fatal(1, "vproc_mem_responder: MEM_LATENCY must be at least 1");
    end
    if ((MEM_SZ & (MEM_SZ - 1)) != 0) begin : g_bad_size
        $fatal(1, "vproc_mem_responder: MEM_SZ must be a power of 2");
    end
    if ((MEM_W % 8) != 0) begin : g_bad_width
        $fatal(1, "vproc_mem_responder: MEM_W must be a multiple of 8");
    end

    logic [MEM_W-1:0]  mem_r [DEPTH];

    logic [31:0]       rel_s;
    logic              err_s;
    logic [AW-BW-1:0]  idx_s;
    logic              wr_en_s;
    logic [MEM_W-1:0]  rd_data_s;

    logic [MEM_LATENCY-1:0] vld_pipe_r;
    logic [MEM_LATENCY-1:0] err_pipe_r;
    logic [MEM_W-1:0]       dat_pipe_r [MEM_LATENCY];

    logic              prog_end_r;
    logic [31:0]       req_cnt_r;
    logic [15:0]       err_cnt_r;

    // Address decode: remove the offset, then anything above the RAM size is an error.
    always_comb begin
        rel_s   = mem_addr_i - ADDR_OFFSET;
        err_s   = (rel_s[31:AW] != '0);
        idx_s   = rel_s[AW-1:BW];
        wr_en_s = mem_req_i & mem_we_i & ~err_s;
    end

    // Read data for the pipeline head; zero for writes, errors and idle cycles.
    always_comb begin
        if (mem_req_i && !mem_we_i && !err_s) begin
            rd_data_s = mem_r[idx_s];
        end else begin
            rd_data_s = '0;
        end
    end

    // Byte-masked RAM write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < NB; b++) begin
            if (wr_en_s && mem_be_i[b]) begin
                mem_r[idx_s][8*b +: 8] <= mem_wdata_i[8*b +: 8];
            end
        end
    end

    // Response shift register: one stage per cycle of latency, in request order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe_r <= '0;
            err_pipe_r <= '0;
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                dat_pipe_r[i] <= '0;
            end
        end else begin
            vld_pipe_r[0] <= mem_req_i;
            err_pipe_r[0] <= mem_req_i & err_s;
            dat_pipe_r[0] <= rd_data_s;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
                err_pipe_r[i] <= err_pipe_r[i-1];
                dat_pipe_r[i] <= dat_pipe_r[i-1];
            end
        end
    end

    // End-of-program flag and request/error statistics.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prog_end_r <= 1'b0;
            req_cnt_r  <= 32'd0;
            err_cnt_r  <= 16'd0;
        end else begin
            prog_end_r <= mem_req_i & (mem_addr_i == 32'h0000_0000);
            if (mem_req_i) begin
                req_cnt_r <= req_cnt_r + 32'd1;
            end
            if (mem_req_i && err_s && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end

    assign mem_rvalid_o = vld_pipe_r[MEM_LATENCY-1];
    assign mem_err_o    = err_pipe_r[MEM_LATENCY-1];
    assign mem_rdata_o  = dat_pipe_r[MEM_LATENCY-1];
    assign prog_end_o   = prog_end_r;
    assign req_cnt_o    = req_cnt_r;
    assign err_cnt_o    = err_cnt_r;

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Directed bench for vproc_mem_responder: three instances cover latency 1, latency 3 and
// latency 4 with a non-zero address offset.
module tb_vproc_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req   [3];
    logic [31:0] addr  [3];
    logic        we    [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic        rvalid[3];
    logic        err   [3];
    logic [31:0] rdata [3];
    logic        pend  [3];
    logic [31:0] rcnt  [3];
    logic [15:0] ecnt  [3];

    int errors = 0;
    int checks = 0;

    vproc_mem_responder #(.MEM_LATENCY(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[0]), .mem_addr_i(addr[0]),
        .mem_we_i(we[0]), .mem_be_i(be[0]), .mem_wdata_i(wdata[0]),
        .mem_rvalid_o(rvalid[0]), .mem_err_o(err[0]), .mem_rdata_o(rdata[0]),
        .prog_end_o(pend[0]), .req_cnt_o(rcnt[0]), .err_cnt_o(ecnt[0]));

    vproc_mem_responder #(.MEM_SZ(4096), .MEM_LATENCY(3)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[1]), .mem_addr_i(addr[1]),
        .mem_we_i(we[1]), .mem_be_i(be[1]), .mem_wdata_i(wdata[1]),
        .mem_rvalid_o(rvalid[1]), .mem_err_o(err[1]), .mem_rdata_o(rdata[1]),
        .prog_end_o(pend[1]), .req_cnt_o(rcnt[1]), .err_cnt_o(ecnt[1]));

    vproc_mem_responder #(.MEM_SZ(4096), .MEM_LATENCY(4), .ADDR_OFFSET(32'h0000_2000)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[2]), .mem_addr_i(addr[2]),
        .mem_we_i(we[2]), .mem_be_i(be[2]), .mem_wdata_i(wdata[2]),
        .mem_rvalid_o(rvalid[2]), .mem_err_o(err[2]), .mem_rdata_o(rdata[2]),
        .prog_end_o(pend[2]), .req_cnt_o(rcnt[2]), .err_cnt_o(ecnt[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] wd);
        req[d]   = r;
        we[d]    = w;
        addr[d]  = a;
        be[d]    = b;
        wdata[d] = wd;
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) idle(d);
        rst_n = 1'b0;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_rvalid%0d", d), {31'b0, rvalid[d]}, 32'h0);
            chk($sformatf("reset_err%0d", d),    {31'b0, err[d]},    32'h0);
            chk($sformatf("reset_rdata%0d", d),  rdata[d],           32'h0);
            chk($sformatf("reset_pend%0d", d),   {31'b0, pend[d]},   32'h0);
            chk($sformatf("reset_rcnt%0d", d),   rcnt[d],            32'h0);
            chk($sformatf("reset_ecnt%0d", d),   {16'b0, ecnt[d]},   32'h0);
        end
        rst_n = 1'b1;
        step();

        // Latency 1: write then read back.
        drive(0, 1'b1, 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF);
        step();
        chk("t1_wr_rvalid", {31'b0, rvalid[0]}, 32'h1);
        chk("t1_wr_rdata",  rdata[0],           32'h0);
        drive(0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        step();
        chk("t1_rd_rvalid", {31'b0, rvalid[0]}, 32'h1);
        chk("t1_rd_rdata",  rdata[0],           32'hDEAD_BEEF);
        chk("t1_rd_err",    {31'b0, err[0]},    32'h0);
        idle(0);
        step();
        chk("t1_idle_rvalid", {31'b0, rvalid[0]}, 32'h0);
        chk("t1_idle_rdata",  rdata[0],           32'h0);

        // Byte enables, including an all-zero enable write.
        drive(0, 1'b1, 1'b1, 32'h40, 4'hF, 32'h1122_3344);
        step();
        drive(0, 1'b1, 1'b1, 32'h40, 4'h5, 32'hAABB_CCDD);
        step();
        drive(0, 1'b1, 1'b1, 32'h40, 4'h0, 32'hFFFF_FFFF);
        step();
        drive(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        step();
        chk("t2_be_rdata", rdata[0], 32'h11BB_33DD);
        idle(0);
        step();
        chk("t2_req_cnt", rcnt[0], 32'd6);

        // Out of range access at MEM_SZ, plus prog_end on address 0.
        drive(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'h1234_5678);
        step();
        chk("t4_pend_wr0", {31'b0, pend[0]}, 32'h1);
        drive(0, 1'b1, 1'b0, 32'h0004_0000, 4'h0, 32'h0);
        step();
        chk("t4_pend_off", {31'b0, pend[0]},   32'h0);
        chk("t4_rd_rvalid", {31'b0, rvalid[0]}, 32'h1);
        chk("t4_rd_err",    {31'b0, err[0]},    32'h1);
        chk("t4_rd_rdata",  rdata[0],           32'h0);
        chk("t4_ecnt1",     {16'b0, ecnt[0]},   32'd1);
        drive(0, 1'b1, 1'b1, 32'h0004_0000, 4'hF, 32'hFFFF_FFFF);
        step();
        chk("t4_wr_err", {31'b0, err[0]},  32'h1);
        chk("t4_ecnt2",  {16'b0, ecnt[0]}, 32'd2);
        drive(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        chk("t4_word0",    rdata[0],          32'h1234_5678);
        chk("t4_word0_err", {31'b0, err[0]},  32'h0);
        chk("t4_pend_rd0", {31'b0, pend[0]},  32'h1);
        idle(0);
        step();
        chk("t4_pend_clr", {31'b0, pend[0]}, 32'h0);
        chk("t4_req_cnt",  rcnt[0],          32'd10);

        // Latency 3: preload, reset (RAM survives), then four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 1'b1, 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i));
            step();
        end
        idle(1);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t3_rcnt_rst", rcnt[1], 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        chk("t3_rvalid_e1", {31'b0, rvalid[1]}, 32'h0);
        chk("t3_pend_e1",   {31'b0, pend[1]},   32'h1);
        drive(1, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
        step();
        chk("t3_rvalid_e2", {31'b0, rvalid[1]}, 32'h0);
        chk("t3_pend_e2",   {31'b0, pend[1]},   32'h0);
        drive(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
        step();
        chk("t3_rvalid_e3", {31'b0, rvalid[1]}, 32'h1);
        chk("t3_rdata0",    rdata[1],           32'hA000_0000);
        drive(1, 1'b1, 1'b0, 32'hC, 4'h0, 32'h0);
        step();
        chk("t3_rdata1",  rdata[1], 32'hA000_0001);
        chk("t3_req_cnt", rcnt[1],  32'd4);
        idle(1);
        step();
        chk("t3_rvalid_e5", {31'b0, rvalid[1]}, 32'h1);
        chk("t3_rdata2",    rdata[1],           32'hA000_0002);
        step();
        chk("t3_rdata3", rdata[1], 32'hA000_0003);
        step();
        chk("t3_rvalid_end", {31'b0, rvalid[1]}, 32'h0);

        // Latency 4 with address offset 0x2000.
        drive(2, 1'b1, 1'b1, 32'h2010, 4'hF, 32'hCAFE_F00D);
        step();
        drive(2, 1'b1, 1'b0, 32'h2010, 4'h0, 32'h0);
        step();
        idle(2);
        step();
        chk("t5_rvalid_early", {31'b0, rvalid[2]}, 32'h0);
        step();
        chk("t5_wr_resp",  {31'b0, rvalid[2]}, 32'h1);
        chk("t5_wr_rdata", rdata[2],           32'h0);
        step();
        chk("t5_rd_rvalid", {31'b0, rvalid[2]}, 32'h1);
        chk("t5_rd_rdata",  rdata[2],           32'hCAFE_F00D);
        drive(2, 1'b1, 1'b0, 32'h1FFC, 4'h0, 32'h0);
        step();
        idle(2);
        repeat (3) step();
        chk("t5_low_rvalid", {31'b0, rvalid[2]}, 32'h1);
        chk("t5_low_err",    {31'b0, err[2]},    32'h1);
        chk("t5_low_rdata",  rdata[2],           32'h0);
        chk("t5_ecnt",       {16'b0, ecnt[2]},   32'd1);
        chk("t5_rcnt",       rcnt[2],            32'd3);

        // Reset mid-flight: in-flight reads dropped, RAM contents kept.
        drive(2, 1'b1, 1'b1, 32'h2020, 4'hF, 32'h5A5A_5A5A);
        step();
        idle(2);
        repeat (4) step();
        drive(2, 1'b1, 1'b0, 32'h2010, 4'h0, 32'h0);
        step();
        drive(2, 1'b1, 1'b0, 32'h2014, 4'h0, 32'h0);
        step();
        drive(2, 1'b1, 1'b0, 32'h2018, 4'h0, 32'h0);
        step();
        idle(2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t6_no_rvalid_%0d", i), {31'b0, rvalid[2]}, 32'h0);
            step();
        end
        chk("t6_rcnt", rcnt[2],           32'h0);
        chk("t6_ecnt", {16'b0, ecnt[2]}, 32'h0);
        drive(2, 1'b1, 1'b0, 32'h2020, 4'h0, 32'h0);
        step();
        idle(2);
        repeat (3) step();
        chk("t6_keep_2020", rdata[2], 32'h5A5A_5A5A);
        drive(2, 1'b1, 1'b0, 32'h2010, 4'h0, 32'h0);
        step();
        idle(2);
        repeat (3) step();
        chk("t6_keep_2010", rdata[2], 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
